// File: rtl/brq_lsu_core.sv
// Load/store unit core: one outstanding bus transaction, optional splitting of
// misaligned accesses into two word transactions, load data assembly and extension.
module brq_lsu_core #(
    parameter bit SplitMisaligned = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_ready_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic [31:0] lsu_err_addr_o
);

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, MIS_ERR} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata1_q, rdata1_d;
    logic [1:0]  type_q, type_d;
    logic        we_q, we_d, sign_q, sign_d, part2_q, part2_d, err_q, err_d;

    logic        idle;
    logic [31:0] cur_addr, cur_wdata, bus_addr;
    logic [1:0]  cur_type;
    logic        cur_we, cur_sign, misaligned;
    logic [3:0]  type_mask;
    logic [7:0]  be_wide;
    logic [4:0]  lane_shift;
    logic [63:0] ld_pair;
    logic [31:0] ld_raw, ld_ext;

    // In IDLE the request is driven straight from the inputs; later the registered copy.
    assign idle      = (state_q == IDLE);
    assign cur_addr  = idle ? lsu_addr_i     : addr_q;
    assign cur_wdata = idle ? lsu_wdata_i    : wdata_q;
    assign cur_type  = idle ? lsu_type_i     : type_q;
    assign cur_we    = idle ? lsu_we_i       : we_q;
    assign cur_sign  = idle ? lsu_sign_ext_i : sign_q;

    assign misaligned = ((cur_type == 2'b00 || cur_type == 2'b11) && cur_addr[1:0] != 2'b00)
                     || (cur_type == 2'b01 && cur_addr[1:0] == 2'b11);

    always_comb begin
        case (cur_type)
            2'b01:   type_mask = 4'b0011;
            2'b10:   type_mask = 4'b0001;
            default: type_mask = 4'b1111;
        endcase
    end

    assign be_wide    = {4'b0000, type_mask} << cur_addr[1:0];
    assign lane_shift = {cur_addr[1:0], 3'b000};
    assign bus_addr   = {cur_addr[31:2], 2'b00} + (part2_q ? 32'd4 : 32'd0);

    assign data_addr_o  = bus_addr;
    assign data_be_o    = part2_q ? be_wide[7:4] : be_wide[3:0];
    assign data_we_o    = data_req_o & cur_we;
    assign data_wdata_o = (cur_wdata << lane_shift) | (cur_wdata >> (6'd32 - {1'b0, lane_shift}));
    assign lsu_ready_o  = idle;

    // Part 2 data sits above part 1 so one right shift aligns either case.
    assign ld_pair = part2_q ? {data_rdata_i, rdata1_q} : {32'h0, data_rdata_i};
    assign ld_raw  = 32'(ld_pair >> lane_shift);

    always_comb begin
        case (cur_type)
            2'b01:   ld_ext = {{16{cur_sign & ld_raw[15]}}, ld_raw[15:0]};
            2'b10:   ld_ext = {{24{cur_sign & ld_raw[7]}}, ld_raw[7:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    assign rf_we_lsu_o    = lsu_resp_valid_o & ~cur_we & ~lsu_resp_err_o;
    assign rf_wdata_lsu_o = rf_we_lsu_o ? ld_ext : 32'h0;

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        type_d           = type_q;
        we_d             = we_q;
        sign_d           = sign_q;
        part2_d          = part2_q;
        err_d            = err_q;
        rdata1_d         = rdata1_q;
        data_req_o       = 1'b0;
        lsu_resp_valid_o = 1'b0;
        lsu_resp_err_o   = 1'b0;
        lsu_err_addr_o   = 32'h0;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    addr_d  = lsu_addr_i;
                    wdata_d = lsu_wdata_i;
                    type_d  = lsu_type_i;
                    we_d    = lsu_we_i;
                    sign_d  = lsu_sign_ext_i;
                    part2_d = 1'b0;
                    err_d   = 1'b0;
                    if (misaligned && !SplitMisaligned) begin
                        state_d = MIS_ERR;
                    end else begin
                        data_req_o = 1'b1;
                        state_d    = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                data_req_o = 1'b1;
                if (data_gnt_i) state_d = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    if (SplitMisaligned && misaligned && !part2_q) begin
                        rdata1_d = data_rdata_i;
                        err_d    = data_err_i;
                        part2_d  = 1'b1;
                        state_d  = WAIT_GNT;
                    end else begin
                        lsu_resp_valid_o = 1'b1;
                        lsu_resp_err_o   = err_q | data_err_i;
                        // A part-1 fault reports the original byte address.
                        if (lsu_resp_err_o)
                            lsu_err_addr_o = (err_q || !part2_q) ? addr_q : bus_addr;
                        part2_d = 1'b0;
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            MIS_ERR: begin
                lsu_resp_valid_o = 1'b1;
                lsu_resp_err_o   = 1'b1;
                lsu_err_addr_o   = addr_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata1_q <= 32'h0;
            type_q   <= 2'b00;
            we_q     <= 1'b0;
            sign_q   <= 1'b0;
            part2_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata1_q <= rdata1_d;
            type_q   <= type_d;
            we_q     <= we_d;
            sign_q   <= sign_d;
            part2_q  <= part2_d;
            err_q    <= err_d;
        end
    end

endmodule
